// File: rtl/mem_stage_pkg.sv
// Shared CPU definitions for the MEM stage: FSM state encoding and ack-timeout default.
package mem_stage_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccess = 2'd1,
        StResp   = 2'd2
    } mem_state_e;

    localparam int unsigned AckTimeoutDefault = 8;
    localparam int unsigned CntWidth          = 4;

endpackage

// File: rtl/mem_stage_if.sv
// Pipeline-side, data-memory and writeback signals of the MEM stage.
interface mem_stage_if;

    logic [15:0] mem_alu_result;
    logic [15:0] mem_rs2_data;
    logic [3:0]  mem_rd;
    logic        mem_reg_write;
    logic        mem_mem_read;
    logic        mem_mem_write;
    logic        mem_mem_to_reg;
    logic        mem_branch;
    logic        mem_branch_ne;
    logic        mem_zero;
    logic [15:0] mem_branch_target;

    logic        dmem_req;
    logic        dmem_we;
    logic [15:0] dmem_addr;
    logic [15:0] dmem_wdata;
    logic [15:0] dmem_rdata;
    logic        dmem_ack;

    logic        stall_mem;
    logic        pc_sel;
    logic [15:0] pc_target;
    logic        flush_mem;
    logic [15:0] wb_result;
    logic [3:0]  wb_rd;
    logic        wb_reg_write;
    logic        mem_fault;

    // Stage side
    modport slave (
        input  mem_alu_result, mem_rs2_data, mem_rd, mem_reg_write, mem_mem_read,
        input  mem_mem_write, mem_mem_to_reg, mem_branch, mem_branch_ne, mem_zero,
        input  mem_branch_target, dmem_rdata, dmem_ack,
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, stall_mem, pc_sel, pc_target,
        output flush_mem, wb_result, wb_rd, wb_reg_write, mem_fault
    );

    // Pipeline / memory side
    modport master (
        output mem_alu_result, mem_rs2_data, mem_rd, mem_reg_write, mem_mem_read,
        output mem_mem_write, mem_mem_to_reg, mem_branch, mem_branch_ne, mem_zero,
        output mem_branch_target, dmem_rdata, dmem_ack,
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, stall_mem, pc_sel, pc_target,
        input  flush_mem, wb_result, wb_rd, wb_reg_write, mem_fault
    );

endinterface

// File: rtl/mem_stage_dmem_access_fsm.sv
// Data-memory access sequencer: IDLE/ACCESS/RESP FSM, ack-wait counter and load buffer.
module dmem_access_fsm
    import mem_stage_pkg::*;
#(
    parameter int unsigned AckTimeout = AckTimeoutDefault
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        access_i,
    input  logic        dmem_ack_i,
    input  logic [15:0] dmem_rdata_i,
    output mem_state_e  state_o,
    output logic        stall_o,
    output logic        dmem_req_o,
    output logic [15:0] load_buf_o,
    output logic        fault_o
);

    localparam logic [CntWidth-1:0] CntLast = CntWidth'(AckTimeout - 1);

    mem_state_e          state_q, state_d;
    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic [15:0]         buf_q, buf_d;
    logic                fault_q, fault_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        fault_d = fault_q;
        case (state_q)
            StIdle: begin
                if (access_i) begin
                    state_d = StAccess;
                    cnt_d   = '0;
                end
            end
            StAccess: begin
                // Ack wins over a coincident timeout
                if (dmem_ack_i) begin
                    state_d = StResp;
                    buf_d   = dmem_rdata_i;
                    cnt_d   = '0;
                end else if (cnt_q == CntLast) begin
                    state_d = StResp;
                    buf_d   = '0;
                    cnt_d   = '0;
                    fault_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            buf_q   <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
            fault_q <= fault_d;
        end
    end

    assign state_o    = state_q;
    assign stall_o    = ((state_q == StIdle) && access_i) || (state_q == StAccess);
    assign dmem_req_o = (state_q == StAccess);
    assign load_buf_o = buf_q;
    assign fault_o    = fault_q;

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: drives data memory via the access FSM, resolves branches, owns the WB register.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned ACK_TIMEOUT = AckTimeoutDefault
) (
    input logic       clk,
    input logic       rst,
    mem_stage_if.slave bus
);

    mem_state_e  state;
    logic [15:0] load_buf;
    logic        access;
    logic        is_branch;
    logic        taken;

    logic [15:0] wb_result_q, wb_result_d;
    logic [3:0]  wb_rd_q, wb_rd_d;
    logic        wb_rw_q, wb_rw_d;

    assign access    = bus.mem_mem_read | bus.mem_mem_write;
    assign is_branch = bus.mem_branch | bus.mem_branch_ne;
    assign taken     = (bus.mem_branch & bus.mem_zero) | (bus.mem_branch_ne & ~bus.mem_zero);

    dmem_access_fsm #(
        .AckTimeout (ACK_TIMEOUT)
    ) u_fsm (
        .clk          (clk),
        .rst          (rst),
        .access_i     (access),
        .dmem_ack_i   (bus.dmem_ack),
        .dmem_rdata_i (bus.dmem_rdata),
        .state_o      (state),
        .stall_o      (bus.stall_mem),
        .dmem_req_o   (bus.dmem_req),
        .load_buf_o   (load_buf),
        .fault_o      (bus.mem_fault)
    );

    // Request fields come straight from the stalled EX2/MEM register
    assign bus.dmem_we    = bus.mem_mem_write;
    assign bus.dmem_addr  = bus.mem_alu_result;
    assign bus.dmem_wdata = bus.mem_rs2_data;

    assign bus.pc_sel    = taken & (state == StIdle);
    assign bus.pc_target = bus.mem_branch_target;
    assign bus.flush_mem = bus.pc_sel;

    always_comb begin
        wb_result_d = wb_result_q;
        wb_rd_d     = wb_rd_q;
        wb_rw_d     = 1'b0;
        case (state)
            StIdle: begin
                if (!access) begin
                    wb_result_d = bus.mem_alu_result;
                    wb_rd_d     = bus.mem_rd;
                    wb_rw_d     = bus.mem_reg_write & ~is_branch;
                end
            end
            StResp: begin
                wb_result_d = bus.mem_mem_to_reg ? load_buf : bus.mem_alu_result;
                wb_rd_d     = bus.mem_rd;
                // Any write (including read+write) never commits to the register file
                wb_rw_d     = bus.mem_reg_write & ~bus.mem_mem_write & ~is_branch;
            end
            default: wb_rw_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_result_q <= '0;
            wb_rd_q     <= '0;
            wb_rw_q     <= 1'b0;
        end else begin
            wb_result_q <= wb_result_d;
            wb_rd_q     <= wb_rd_d;
            wb_rw_q     <= wb_rw_d;
        end
    end

    assign bus.wb_result    = wb_result_q;
    assign bus.wb_rd        = wb_rd_q;
    assign bus.wb_reg_write = wb_rw_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed vector table, reset sequence, random transactions.
module tb_mem_stage;

    localparam int AckTo = 8;

    typedef struct {
        logic [15:0] alu;
        logic [15:0] rs2;
        logic [3:0]  rd;
        logic        rw;
        logic        mrd;
        logic        wr;
        logic        m2r;
        logic        br;
        logic        bne;
        logic        zero;
        logic [15:0] tgt;
        int          ack_at;  // ACCESS cycle (1-based) that sees ack; 0 = never
        logic [15:0] rdata;
        logic [15:0] e_res;
        logic        e_rw;
        int          e_stall;
        logic        e_pcsel;
        logic        e_fault;
    } vec_t;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    logic fault_m;

    mem_stage_if bus ();

    mem_stage #(
        .ACK_TIMEOUT (AckTo)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [15:0] alu, input logic [15:0] rs2,
                                input logic [3:0] rd, input logic rw, input logic mrd,
                                input logic wr, input logic m2r, input logic br,
                                input logic bne, input logic zero, input logic [15:0] tgt,
                                input int ack_at, input logic [15:0] rdata,
                                input logic [15:0] e_res, input logic e_rw, input int e_stall,
                                input logic e_pcsel, input logic e_fault);
        vec_t v;
        v.alu = alu; v.rs2 = rs2; v.rd = rd; v.rw = rw; v.mrd = mrd; v.wr = wr; v.m2r = m2r;
        v.br = br; v.bne = bne; v.zero = zero; v.tgt = tgt; v.ack_at = ack_at;
        v.rdata = rdata; v.e_res = e_res; v.e_rw = e_rw; v.e_stall = e_stall;
        v.e_pcsel = e_pcsel; v.e_fault = e_fault;
        return v;
    endfunction

    task automatic drive_idle();
        bus.mem_alu_result = '0; bus.mem_rs2_data = '0; bus.mem_rd = '0;
        bus.mem_reg_write = 0; bus.mem_mem_read = 0; bus.mem_mem_write = 0;
        bus.mem_mem_to_reg = 0; bus.mem_branch = 0; bus.mem_branch_ne = 0; bus.mem_zero = 0;
        bus.mem_branch_target = '0; bus.dmem_rdata = '0; bus.dmem_ack = 0;
    endtask

    // Called at negedge+1 with the stage in IDLE; returns one negedge after the WB update.
    task automatic run_vec(input vec_t v, input string tag);
        int   stalls;
        int   acc;
        logic req_bad;
        logic bub_bad;
        bus.mem_alu_result = v.alu; bus.mem_rs2_data = v.rs2; bus.mem_rd = v.rd;
        bus.mem_reg_write = v.rw; bus.mem_mem_read = v.mrd; bus.mem_mem_write = v.wr;
        bus.mem_mem_to_reg = v.m2r; bus.mem_branch = v.br; bus.mem_branch_ne = v.bne;
        bus.mem_zero = v.zero; bus.mem_branch_target = v.tgt;
        bus.dmem_ack = 0; bus.dmem_rdata = v.rdata;
        #1;
        chk({tag, " pc_sel"}, 32'(bus.pc_sel), 32'(v.e_pcsel));
        chk({tag, " flush_mem"}, 32'(bus.flush_mem), 32'(v.e_pcsel));
        chk({tag, " pc_target"}, 32'(bus.pc_target), 32'(v.tgt));
        stalls = 0; acc = 0; req_bad = 0; bub_bad = 0;
        while (bus.stall_mem && stalls < 40) begin
            if (stalls > 0 && bus.wb_reg_write) bub_bad = 1;
            if (bus.dmem_req) begin
                acc++;
                if (bus.dmem_we !== v.wr || bus.dmem_addr !== v.alu || bus.dmem_wdata !== v.rs2)
                    req_bad = 1;
                bus.dmem_ack = (acc == v.ack_at);
            end
            stalls++;
            @(negedge clk);
            bus.dmem_ack = 0;
            #1;
        end
        chk({tag, " stall_cycles"}, 32'(stalls), 32'(v.e_stall));
        if (v.e_stall > 0) begin
            chk({tag, " req_fields"}, 32'(req_bad), 32'(0));
            chk({tag, " access_bubble"}, 32'(bub_bad | bus.wb_reg_write), 32'(0));
            chk({tag, " req_in_resp"}, 32'(bus.dmem_req), 32'(0));
        end
        @(negedge clk);
        #1;
        chk({tag, " wb_reg_write"}, 32'(bus.wb_reg_write), 32'(v.e_rw));
        if (v.e_rw) begin
            chk({tag, " wb_result"}, 32'(bus.wb_result), 32'(v.e_res));
            chk({tag, " wb_rd"}, 32'(bus.wb_rd), 32'(v.rd));
        end
        chk({tag, " mem_fault"}, 32'(bus.mem_fault), 32'(v.e_fault));
    endtask

    vec_t vecs[12];

    initial begin
        checks = 0; failures = 0; fault_m = 0;
        //         alu       rs2       rd rw rd wr m2r br bne z tgt  ack rdata    e_res   rw st pc flt
        vecs[0]  = mk(16'h1234, 16'h0000, 3, 1, 0, 0, 0, 0, 0, 0, 16'h0000, 0, 16'h0000,
                      16'h1234, 1, 0, 0, 0);
        vecs[1]  = mk(16'h0040, 16'h0000, 5, 1, 1, 0, 1, 0, 0, 0, 16'h0000, 3, 16'hBEEF,
                      16'hBEEF, 1, 4, 0, 0);
        vecs[2]  = mk(16'h0010, 16'h00AA, 0, 0, 0, 1, 0, 0, 0, 0, 16'h0000, 1, 16'h5555,
                      16'h0010, 0, 2, 0, 0);
        vecs[3]  = mk(16'h0777, 16'h0000, 7, 1, 0, 0, 0, 0, 1, 0, 16'h0200, 0, 16'h0000,
                      16'h0777, 0, 0, 1, 0);
        vecs[4]  = mk(16'h0777, 16'h0000, 7, 1, 0, 0, 0, 0, 1, 1, 16'h0200, 0, 16'h0000,
                      16'h0777, 0, 0, 0, 0);
        vecs[5]  = mk(16'h0101, 16'h0000, 1, 0, 0, 0, 0, 1, 0, 1, 16'h0340, 0, 16'h0000,
                      16'h0101, 0, 0, 1, 0);
        vecs[6]  = mk(16'h0022, 16'h3333, 4, 1, 1, 1, 1, 0, 0, 0, 16'h0000, 2, 16'hCAFE,
                      16'hCAFE, 0, 3, 0, 0);
        vecs[7]  = mk(16'h0050, 16'h0000, 6, 1, 1, 0, 0, 0, 0, 0, 16'h0000, 1, 16'h1111,
                      16'h0050, 1, 2, 0, 0);
        vecs[8]  = mk(16'h0060, 16'h0000, 8, 1, 1, 0, 1, 0, 0, 0, 16'h0000, 8, 16'h8888,
                      16'h8888, 1, 9, 0, 0);
        vecs[9]  = mk(16'h0070, 16'h0000, 9, 1, 1, 0, 1, 0, 0, 0, 16'h0000, 0, 16'hDEAD,
                      16'h0000, 1, 9, 0, 1);
        vecs[10] = mk(16'h00FF, 16'h0000, 2, 1, 0, 0, 0, 0, 0, 0, 16'h0000, 0, 16'h0000,
                      16'h00FF, 1, 0, 0, 1);
        vecs[11] = mk(16'h0012, 16'h0034, 0, 0, 0, 1, 0, 0, 0, 0, 16'h0000, 1, 16'h0000,
                      16'h0012, 0, 2, 0, 1);

        drive_idle();
        rst = 1;
        #2 rst = 0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset wb_result", 32'(bus.wb_result), 32'(0));
        chk("reset wb_rd", 32'(bus.wb_rd), 32'(0));
        chk("reset wb_reg_write", 32'(bus.wb_reg_write), 32'(0));
        chk("reset mem_fault", 32'(bus.mem_fault), 32'(0));
        chk("reset dmem_req", 32'(bus.dmem_req), 32'(0));
        chk("reset stall_mem", 32'(bus.stall_mem), 32'(0));
        @(negedge clk);
        rst = 1;
        #1;

        for (int i = 0; i < 12; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Reset in the middle of an ACCESS
        bus.mem_alu_result = 16'h0040; bus.mem_rd = 4'd5; bus.mem_reg_write = 1;
        bus.mem_mem_read = 1; bus.mem_mem_to_reg = 1; bus.dmem_ack = 0;
        #1;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rstseq req_before", 32'(bus.dmem_req), 32'(1));
        rst = 0;
        #1;
        chk("rstseq dmem_req", 32'(bus.dmem_req), 32'(0));
        chk("rstseq wb_result", 32'(bus.wb_result), 32'(0));
        chk("rstseq wb_rd", 32'(bus.wb_rd), 32'(0));
        chk("rstseq wb_reg_write", 32'(bus.wb_reg_write), 32'(0));
        chk("rstseq mem_fault", 32'(bus.mem_fault), 32'(0));
        drive_idle();
        @(negedge clk);
        rst = 1;
        #1;
        run_vec(mk(16'h4321, 16'h0000, 10, 1, 0, 0, 0, 0, 0, 0, 16'h0000, 0, 16'h0000,
                   16'h4321, 1, 0, 0, 0), "rstseq alu");

        // Random transactions against a transaction-level model
        for (int n = 0; n < 150; n++) begin
            vec_t v;
            logic mem;
            logic acked;
            int   k;
            v.alu = 16'($urandom); v.rs2 = 16'($urandom); v.rd = 4'($urandom);
            v.rw = 1'($urandom); v.mrd = ($urandom_range(0, 2) == 0);
            v.wr = ($urandom_range(0, 3) == 0); v.m2r = 1'($urandom);
            v.br = ($urandom_range(0, 4) == 0); v.bne = ($urandom_range(0, 4) == 0);
            v.zero = 1'($urandom); v.tgt = 16'($urandom);
            v.ack_at = $urandom_range(0, 10); v.rdata = 16'($urandom);
            mem   = v.mrd | v.wr;
            acked = (v.ack_at >= 1) && (v.ack_at <= AckTo);
            k     = acked ? v.ack_at : AckTo;
            v.e_stall = mem ? 1 + k : 0;
            v.e_pcsel = (v.br & v.zero) | (v.bne & ~v.zero);
            v.e_res   = (mem && v.m2r) ? (acked ? v.rdata : 16'h0000) : v.alu;
            v.e_rw    = v.rw & ~(v.br | v.bne) & ~v.wr;
            if (mem && !acked) fault_m = 1;
            v.e_fault = fault_m;
            run_vec(v, $sformatf("rand%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
